// File: rtl/bram_port_ctrl_if.sv
// Request/response and BRAM-pin bundle for bram_port_ctrl.
// Requester side: req_* / init_start in, req_ready / init_done / rsp_* out.
// Memory side: mem_wce / mem_rce / mem_addr / mem_wd out, mem_rq in (registered BRAM output).
interface bram_port_ctrl_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 36
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              init_start;
  logic              init_done;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_data;
  logic              mem_wce;
  logic              mem_rce;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wd;
  logic [DWIDTH-1:0] mem_rq;

  // Environment side: requester plus the BRAM itself.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, init_start, mem_rq,
    input  req_ready, init_done, rsp_valid, rsp_data,
    input  mem_wce, mem_rce, mem_addr, mem_wd
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, init_start, mem_rq,
    output req_ready, init_done, rsp_valid, rsp_data,
    output mem_wce, mem_rce, mem_addr, mem_wd
  );
endinterface

// File: rtl/bram_port_ctrl.sv
// Single-port BRAM front end: fills the whole array with INIT_VAL after reset or
// on init_start, then issues one read/write per cycle. Read latency 2 cycles.
// Backpressure: req_ready low only while clearing; the response path never stalls.
// Ports: clk, rst_n (async active-low), bus (bram_port_ctrl_if.slave).
module bram_port_ctrl #(
  parameter int              AWIDTH   = 10,
  parameter int              DWIDTH   = 36,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  bram_port_ctrl_if.slave bus
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state_q,     state_d;
  // One extra bit so the terminal count (2^AWIDTH) is distinguishable from 0.
  logic [AWIDTH:0]   cnt_q,       cnt_d;
  logic              mem_wce_q,   mem_wce_d;
  logic              mem_rce_q,   mem_rce_d;
  logic [AWIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DWIDTH-1:0] mem_wd_q,    mem_wd_d;
  logic              rsp_valid_q, rsp_valid_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_wce_d   = 1'b0;
    mem_rce_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    // BRAM data appears the cycle after mem_rce, so the response flag trails it by one.
    rsp_valid_d = mem_rce_q;

    case (state_q)
      ST_CLEAR: begin
        if (cnt_q[AWIDTH]) begin
          // Last address was written in the cycle just ending.
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          mem_wce_d  = 1'b1;
          mem_addr_d = cnt_q[AWIDTH-1:0];
          mem_wd_d   = INIT_VAL;
          cnt_d      = cnt_q + (AWIDTH+1)'(1);
        end
      end
      default: begin
        if (bus.req_valid) begin
          mem_wce_d  = bus.req_we;
          mem_rce_d  = ~bus.req_we;
          mem_addr_d = bus.req_addr;
          if (bus.req_we) begin
            mem_wd_d = bus.req_wdata;
          end
        end
        // A request accepted alongside init_start is still issued above.
        if (bus.init_start) begin
          state_d = ST_CLEAR;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      mem_wce_q   <= 1'b0;
      mem_rce_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wd_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_wce_q   <= mem_wce_d;
      mem_rce_q   <= mem_rce_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready = (state_q == ST_RUN);
  assign bus.init_done = (state_q == ST_RUN);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = bus.mem_rq;
  assign bus.mem_wce   = mem_wce_q;
  assign bus.mem_rce   = mem_rce_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wd    = mem_wd_q;

endmodule
